// File: rtl/wb_rr_arbiter_if.sv
// Wishbone classic bus bundle shared by the masters and the slave port.
// master drives cyc/stb/we/adr/dat_w; slave drives ack/err/rty/dat_r.
interface wb_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic                  ack;
  logic                  err;
  logic                  rty;
  logic [DATA_WIDTH-1:0] dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  ack, err, rty, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output ack, err, rty, dat_r
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with cyc bus lock and watchdog.
// Ports: clk_i, rst_ni, wbm0/wbm1 (master buses), wbs (slave bus), grant_o, timeout_o.
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wb_rr_arbiter_if.slave        wbm0,
  wb_rr_arbiter_if.slave        wbm1,
  wb_rr_arbiter_if.master       wbs,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  localparam logic [7:0] TO_L  = 8'(TIMEOUT);
  localparam bit         WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic [7:0] wd_q, wd_d;

  logic                  g0, g1;
  logic                  m_cyc, m_stb, m_we;
  logic [ADDR_WIDTH-1:0] m_adr;
  logic [DATA_WIDTH-1:0] m_dat;
  logic                  resp, fire;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_adr = '0;
    m_dat = '0;
    unique case (1'b1)
      g0: begin
        m_cyc = wbm0.cyc;
        m_stb = wbm0.cyc & wbm0.stb;
        m_we  = wbm0.cyc & wbm0.we;
        m_adr = wbm0.cyc ? wbm0.adr : '0;
        m_dat = wbm0.cyc ? wbm0.dat_w : '0;
      end
      g1: begin
        m_cyc = wbm1.cyc;
        m_stb = wbm1.cyc & wbm1.stb;
        m_we  = wbm1.cyc & wbm1.we;
        m_adr = wbm1.cyc ? wbm1.adr : '0;
        m_dat = wbm1.cyc ? wbm1.dat_w : '0;
      end
      default: ;
    endcase
  end

  assign resp = wbs.ack | wbs.err | wbs.rty;
  // a real response always beats the watchdog
  assign fire = WD_EN && m_stb && !resp && (wd_q == TO_L);

  assign wbs.cyc   = m_cyc & ~fire;
  assign wbs.stb   = m_stb & ~fire;
  assign wbs.we    = m_we;
  assign wbs.adr   = m_adr;
  assign wbs.dat_w = m_dat;

  assign wbm0.ack   = g0 & wbs.ack;
  assign wbm0.err   = g0 & (wbs.err | fire);
  assign wbm0.rty   = g0 & wbs.rty;
  assign wbm0.dat_r = g0 ? wbs.dat_r : '0;

  assign wbm1.ack   = g1 & wbs.ack;
  assign wbm1.err   = g1 & (wbs.err | fire);
  assign wbm1.rty   = g1 & wbs.rty;
  assign wbm1.dat_r = g1 ? wbs.dat_r : '0;

  assign grant_o   = {g1, g0};
  assign timeout_o = fire;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = 8'd0;
    unique case (state_q)
      IDLE: begin
        // on a tie, last_q==1 means master 0 is owed the bus
        if (wbm0.cyc && (!wbm1.cyc || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (wbm1.cyc) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: if (!wbm0.cyc) state_d = IDLE;
      GNT1: if (!wbm1.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (m_stb && !resp && !fire) wd_d = wd_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule
